// File: rtl/invaders_pkg.sv
// rtl/invaders_pkg.sv - shared game state type, scoring constants and life cap
package invaders_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PLAYING   = 2'd1,
    PAUSE     = 2'd2,
    GAME_OVER = 2'd3
  } game_state_t;

  // Points per kill as two packed BCD digits
  localparam logic [7:0] ROW0_POINTS = 8'h30;
  localparam logic [7:0] ROW1_POINTS = 8'h20;
  localparam logic [7:0] ROWN_POINTS = 8'h10;

  localparam int MAX_LIVES = 7;

  function automatic logic [7:0] row_points(input int unsigned row);
    case (row)
      0:       return ROW0_POINTS;
      1:       return ROW1_POINTS;
      default: return ROWN_POINTS;
    endcase
  endfunction

endpackage

// File: rtl/bcd_score_adder.sv
// rtl/bcd_score_adder.sv - packed BCD score plus two-digit BCD points, saturating at all nines
module bcd_score_adder #(
  parameter int DIGITS = 4
) (
  input  logic [4*DIGITS-1:0] score_in,
  input  logic [7:0]          points,
  output logic [4*DIGITS-1:0] score_out
);

  logic [4*DIGITS-1:0] addend;
  logic [4*DIGITS-1:0] raw;
  logic [4*DIGITS-1:0] nines;
  logic [4:0]          digit_sum;
  logic                carry;

  always_comb begin
    addend      = '0;
    addend[7:0] = points;
    raw         = '0;
    nines       = '0;
    carry       = 1'b0;
    digit_sum   = '0;
    for (int d = 0; d < DIGITS; d++) begin
      digit_sum = {1'b0, score_in[4*d +: 4]} + {1'b0, addend[4*d +: 4]} + {4'b0, carry};
      if (digit_sum > 5'd9) begin
        raw[4*d +: 4] = 4'(digit_sum - 5'd10);
        carry         = 1'b1;
      end else begin
        raw[4*d +: 4] = digit_sum[3:0];
        carry         = 1'b0;
      end
      nines[4*d +: 4] = 4'h9;
    end
    // A carry out of the top digit means the score would wrap; clamp instead
    score_out = carry ? nines : raw;
  end

endmodule

// File: rtl/invaders_game_ctrl.sv
// rtl/invaders_game_ctrl.sv - invaders game state, collisions, score, lives and waves
// Optional extra life at 1000 points when INVADERS_EXTRA_LIFE_EN is defined.
module invaders_game_ctrl
  import invaders_pkg::*;
#(
  parameter int NUM_ROWS       = 3,
  parameter int NUM_COLUMNS    = 5,
  parameter int START_LIVES    = 3,
  parameter int RESPAWN_FRAMES = 60,
  parameter int WAVE_FRAMES    = 90,
  parameter int SCORE_DIGITS   = 4
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  frame_tick,
  input  logic                                  display_on,
  input  logic                                  laser_gfx,
  input  logic                                  alien_pixel,
  input  logic [$clog2(NUM_ROWS)-1:0]           alien_row,
  input  logic [$clog2(NUM_COLUMNS)-1:0]        alien_col,
  input  logic                                  bomb_gfx,
  input  logic                                  cannon_gfx,
  input  logic                                  start,
  output logic [NUM_ROWS-1:0][NUM_COLUMNS-1:0]  alive_matrix,
  output logic                                  hit_alien,
  output logic [4*SCORE_DIGITS-1:0]             score,
  output logic [2:0]                            lives,
  output logic [7:0]                            wave,
  output game_state_t                           game_state,
  output logic                                  freeze
);

  localparam int ROW_W     = $clog2(NUM_ROWS);
  localparam int COL_W     = $clog2(NUM_COLUMNS);
  localparam int SCORE_W   = 4 * SCORE_DIGITS;
  localparam int PAUSE_MAX = (RESPAWN_FRAMES > WAVE_FRAMES) ? RESPAWN_FRAMES : WAVE_FRAMES;
  localparam int PAUSE_W   = $clog2(PAUSE_MAX + 1);

  localparam logic [PAUSE_W-1:0] RESPAWN_CNT = PAUSE_W'(RESPAWN_FRAMES);
  localparam logic [PAUSE_W-1:0] WAVE_CNT    = PAUSE_W'(WAVE_FRAMES);
  localparam logic [PAUSE_W-1:0] BOTH_CNT    = PAUSE_W'(PAUSE_MAX);
  localparam logic [ROW_W-1:0]   ROW_LAST    = ROW_W'(NUM_ROWS - 1);
  localparam logic [COL_W-1:0]   COL_LAST    = COL_W'(NUM_COLUMNS - 1);

  typedef logic [NUM_ROWS-1:0][NUM_COLUMNS-1:0] alive_t;

  game_state_t        state_q, state_d;
  logic [SCORE_W-1:0] score_q, score_d, score_sum;
  logic [2:0]         lives_q, lives_d;
  logic [7:0]         wave_q, wave_d;
  alive_t             alive_q, alive_d, alive_killed;
  logic               hit_q, hit_d;
  logic               kill_lat_q, kill_lat_d;
  logic [ROW_W-1:0]   kill_row_q, kill_row_d;
  logic [COL_W-1:0]   kill_col_q, kill_col_d;
  logic               hit_lat_q, hit_lat_d;
  logic [PAUSE_W-1:0] pause_q, pause_d;
  logic               refill_q, refill_d;
  logic               tick_q;
  logic               start_q;

  logic               start_rise;
  logic               kill_now;
  logic               player_hit_now;
  logic [7:0]         kill_points;
  logic [3:0]         lives_calc;
  logic               wave_clear;

`ifdef INVADERS_EXTRA_LIFE_EN
  logic               bonus_q, bonus_d;
  logic               score_big;

  always_comb begin
    score_big = 1'b0;
    for (int d = 3; d < SCORE_DIGITS; d++) begin
      if (score_sum[4*d +: 4] != 4'd0) score_big = 1'b1;
    end
  end
`endif

  assign start_rise     = start & ~start_q;
  assign player_hit_now = display_on & bomb_gfx & cannon_gfx;
  assign kill_points    = row_points(32'(kill_row_q));

  always_comb begin
    kill_now = 1'b0;
    if (display_on && laser_gfx && alien_pixel && (alien_row <= ROW_LAST) && (alien_col <= COL_LAST))
      kill_now = alive_q[alien_row][alien_col];
  end

  always_comb begin
    alive_killed                         = alive_q;
    alive_killed[kill_row_q][kill_col_q] = 1'b0;
  end

  bcd_score_adder #(
    .DIGITS(SCORE_DIGITS)
  ) u_score_adder (
    .score_in (score_q),
    .points   (kill_points),
    .score_out(score_sum)
  );

  always_comb begin
    state_d    = state_q;
    score_d    = score_q;
    lives_d    = lives_q;
    wave_d     = wave_q;
    alive_d    = alive_q;
    hit_d      = 1'b0;
    kill_lat_d = kill_lat_q;
    kill_row_d = kill_row_q;
    kill_col_d = kill_col_q;
    hit_lat_d  = hit_lat_q;
    pause_d    = pause_q;
    refill_d   = refill_q;
    lives_calc = {1'b0, lives_q};
    wave_clear = 1'b0;
`ifdef INVADERS_EXTRA_LIFE_EN
    bonus_d    = bonus_q;
`endif
    case (state_q)
      IDLE, GAME_OVER: begin
        if (start_rise) begin
          state_d    = PLAYING;
          score_d    = '0;
          lives_d    = 3'(START_LIVES);
          wave_d     = 8'd1;
          alive_d    = '1;
          kill_lat_d = 1'b0;
          hit_lat_d  = 1'b0;
          pause_d    = '0;
          refill_d   = 1'b0;
`ifdef INVADERS_EXTRA_LIFE_EN
          bonus_d    = 1'b0;
`endif
        end
      end
      PLAYING: begin
        if (tick_q) begin
          // Frame boundary: commit whatever the previous frame latched
          kill_lat_d = 1'b0;
          hit_lat_d  = 1'b0;
          if (kill_lat_q) begin
            alive_d    = alive_killed;
            score_d    = score_sum;
            hit_d      = 1'b1;
            wave_clear = (alive_killed == '0);
          end
          if (hit_lat_q) lives_calc = lives_calc - 4'd1;
`ifdef INVADERS_EXTRA_LIFE_EN
          if (kill_lat_q && !bonus_q && score_big) begin
            bonus_d = 1'b1;
            if (lives_calc < 4'(MAX_LIVES)) lives_calc = lives_calc + 4'd1;
          end
`endif
          lives_d = lives_calc[2:0];
          if (hit_lat_q && (lives_calc == 4'd0)) begin
            state_d = GAME_OVER;
          end else if (hit_lat_q || wave_clear) begin
            state_d  = PAUSE;
            refill_d = wave_clear;
            if (hit_lat_q && wave_clear) pause_d = BOTH_CNT;
            else if (hit_lat_q)          pause_d = RESPAWN_CNT;
            else                         pause_d = WAVE_CNT;
          end
        end else begin
          if (!kill_lat_q && kill_now) begin
            kill_lat_d = 1'b1;
            kill_row_d = alien_row;
            kill_col_d = alien_col;
          end
          if (player_hit_now) hit_lat_d = 1'b1;
        end
      end
      PAUSE: begin
        if (frame_tick) begin
          if (pause_q <= PAUSE_W'(1)) begin
            state_d = PLAYING;
            pause_d = '0;
            if (refill_q) begin
              alive_d  = '1;
              wave_d   = (wave_q == 8'd255) ? 8'd1 : wave_q + 8'd1;
              refill_d = 1'b0;
            end
          end else begin
            pause_d = pause_q - PAUSE_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      score_q    <= '0;
      lives_q    <= 3'(START_LIVES);
      wave_q     <= '0;
      alive_q    <= '1;
      hit_q      <= 1'b0;
      kill_lat_q <= 1'b0;
      kill_row_q <= '0;
      kill_col_q <= '0;
      hit_lat_q  <= 1'b0;
      pause_q    <= '0;
      refill_q   <= 1'b0;
      tick_q     <= 1'b0;
      start_q    <= 1'b0;
`ifdef INVADERS_EXTRA_LIFE_EN
      bonus_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      score_q    <= score_d;
      lives_q    <= lives_d;
      wave_q     <= wave_d;
      alive_q    <= alive_d;
      hit_q      <= hit_d;
      kill_lat_q <= kill_lat_d;
      kill_row_q <= kill_row_d;
      kill_col_q <= kill_col_d;
      hit_lat_q  <= hit_lat_d;
      pause_q    <= pause_d;
      refill_q   <= refill_d;
      tick_q     <= frame_tick;
      start_q    <= start;
`ifdef INVADERS_EXTRA_LIFE_EN
      bonus_q    <= bonus_d;
`endif
    end
  end

  assign alive_matrix = alive_q;
  assign hit_alien    = hit_q;
  assign score        = score_q;
  assign lives        = lives_q;
  assign wave         = wave_q;
  assign game_state   = state_q;
  assign freeze       = (state_q != PLAYING);

endmodule

// File: doc/invaders_game_ctrl.md
INVADERS_GAME_CTRL -- requirements
Module: invaders_game_ctrl

Interface
REQ-001 SHALL have parameter NUM_ROWS, default 3, number of alien rows.
REQ-002 SHALL have parameter NUM_COLUMNS, default 5, number of alien columns.
REQ-003 SHALL have parameter START_LIVES, default 3, lives at game start (1..7).
REQ-004 SHALL have parameter RESPAWN_FRAMES, default 60, frozen frames after player hit.
REQ-005 SHALL have parameter WAVE_FRAMES, default 90, pause frames between waves.
REQ-006 SHALL have parameter SCORE_DIGITS, default 4, BCD score digits.
REQ-007 SHALL have ports:
 clk  in  1  pixel clock; only clock
 reset  in  1  synchronous, active-high
 frame_tick  in  1  one-cycle pulse at start of vertical blank
 display_on  in  1  scan inside visible area
 laser_gfx  in  1  laser pixel lit
 alien_pixel  in  1  alien pixel lit
 alien_row  in  $clog2(NUM_ROWS)  row of alien under scan
 alien_col  in  $clog2(NUM_COLUMNS)  column of alien under scan
 bomb_gfx  in  1  alien bomb pixel lit
 cannon_gfx  in  1  cannon pixel lit
 start  in  1  start button, already synchronised
 alive_matrix  out  NUM_ROWS x NUM_COLUMNS  alien alive flags
 hit_alien  out  1  one-cycle pulse, alien killed (clears laser)
 score  out  4*SCORE_DIGITS  packed BCD score
 lives  out  3  remaining lives
 wave  out  8  wave number
 game_state  out  2  current state (game_state_t)
 freeze  out  1  high whenever game_state != PLAYING

Function
REQ-008 SHALL implement FSM IDLE, PLAYING, PAUSE, GAME_OVER; PAUSE covers respawn and wave-clear.
REQ-009 SHALL detect rising edge of start; in IDLE or GAME_OVER it enters PLAYING next cycle with score 0, lives START_LIVES, wave 1, alive_matrix all ones.
REQ-010 SHALL, in PLAYING, latch the first kill of a frame when display_on & laser_gfx & alien_pixel & alive_matrix[alien_row][alien_col]; later coincidences in the same frame ignored.
REQ-011 SHALL latch a player hit when display_on & bomb_gfx & cannon_gfx in PLAYING.
REQ-012 SHALL apply latched events on the cycle after frame_tick, then clear latches; max one kill per frame.
REQ-013 SHALL on kill: clear alive bit, pulse hit_alien for exactly one cycle, add 30 (row 0), 20 (row 1) or 10 (other rows) to score in BCD.
REQ-014 SHALL saturate score at all-nines; no wrap.
REQ-015 SHALL on player hit: decrement lives; if result 0 enter GAME_OVER, else PAUSE for RESPAWN_FRAMES frame_ticks then PLAYING.
REQ-016 SHALL when the kill empties alive_matrix and lives remain: PAUSE WAVE_FRAMES frame_ticks, then refill alive_matrix, increment wave (wraps 255->1), return PLAYING.
REQ-017 SHALL on simultaneous kill and player hit in one frame apply both; GAME_OVER wins over wave clear; otherwise pause length = max of the two.
REQ-018 SHALL ignore all collision inputs outside PLAYING; start ignored in PLAYING/PAUSE.
REQ-019 SHALL count pause frames with a counter wide enough for max(RESPAWN_FRAMES, WAVE_FRAMES).

Reset
REQ-020 SHALL on reset (any cycle, including mid-pause or mid-hit): game_state IDLE, score 0, lives START_LIVES, wave 0, alive_matrix all ones, hit_alien 0, latches and counters 0; freeze 1.

Configuration
REQ-021 SHALL with INVADERS_EXTRA_LIFE_EN defined award one extra life (capped at 7) on the cycle score first reaches or crosses 1000 (needs SCORE_DIGITS>=4), once per game.
REQ-022 SHALL without INVADERS_EXTRA_LIFE_EN never increase lives except at game start.

Structure
REQ-023 SHALL place game_state_t, row point constants and MAX_LIVES in package invaders_pkg.
REQ-024 SHALL implement BCD add-with-saturation in sub-module bcd_score_adder.

Verification
REQ-025 Reset, pulse start -> next cycle PLAYING, lives 3, score 0, wave 1, alive all ones.
REQ-026 Laser/alien overlap at row 0 col 2, frame_tick -> alive[0][2]=0, hit_alien one cycle, score 0x0030; second overlap same frame -> no extra score.
REQ-027 Three bomb/cannon hits across frames -> lives 2, 1 (each PAUSE 60 frames), then GAME_OVER at 0.
REQ-028 Kill all 15 aliens -> PAUSE 90 frames, then alive all ones, wave 2, PLAYING.
REQ-029 Score preset near 9990 with row-0 kill -> score 0x9999; with INVADERS_EXTRA_LIFE_EN, crossing 1000 -> lives+1 once.
REQ-030 Assert reset during PAUSE -> IDLE next cycle, all outputs at reset values.
